// File: rtl/i2c_target_regs_if.sv
// Open-drain I2C pin bundle: pin levels seen by the target and its SDA pull-down enable.
interface i2c_target_regs_if;
  logic scl_i;
  logic sda_i;
  logic sda_oe;

  modport master (output scl_i, output sda_i, input sda_oe);
  modport slave  (input scl_i, input sda_i, output sda_oe);
endinterface

// File: rtl/i2c_target_regs.sv
// I2C target holding one 16-bit word: written as MSB/LSB byte pairs and read back
// in the same order. SCL/SDA are oversampled by HCLK; SCL is never stretched.
module i2c_target_regs #(
  parameter logic [6:0] ADDR        = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  i2c_target_regs_if.slave  bus,
  output logic [15:0]       i2c_data,
  output logic              data_valid,
  output logic              busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_BYTE, S_WR_ACK, S_RD_BYTE, S_RD_ACK
  } state_t;

  function automatic logic [7:0] f_rd_byte(input logic idx, input logic [15:0] d);
    return idx ? d[7:0] : d[15:8];
  endfunction

  logic [SYNC_STAGES-1:0] r_scl_sync, r_sda_sync;
  logic                   r_scl_d, r_sda_d;
  state_t                 r_state, w_state_nxt;
  logic [3:0]             r_bit_cnt, w_bit_cnt_nxt;
  logic [7:0]             r_shift, w_shift_nxt;
  logic [7:0]             r_msb, w_msb_nxt;
  logic                   r_byte_idx, w_byte_idx_nxt;
  logic                   r_rw, w_rw_nxt;
  logic                   r_ack_drv, w_ack_drv_nxt;
  logic                   r_sda_oe, w_sda_oe_nxt;
  logic [15:0]            r_data, w_data_nxt;
  logic                   r_dv, w_dv_nxt;
  logic                   r_busy, w_busy_nxt;
  logic                   w_scl, w_sda;
  logic                   w_scl_rise, w_scl_fall, w_start, w_stop;
  logic [7:0]             w_byte_in;

  assign w_scl      = r_scl_sync[SYNC_STAGES-1];
  assign w_sda      = r_sda_sync[SYNC_STAGES-1];
  assign w_scl_rise = w_scl & ~r_scl_d;
  assign w_scl_fall = ~w_scl & r_scl_d;
  assign w_start    = ~w_sda & r_sda_d & w_scl;
  assign w_stop     = w_sda & ~r_sda_d & w_scl;
  assign w_byte_in  = {r_shift[6:0], w_sda};

  assign bus.sda_oe = r_sda_oe;
  assign i2c_data   = r_data;
  assign data_valid = r_dv;
  assign busy       = r_busy;

  // Pin synchronizers plus edge-detect delay; reset to idle-high so reset exit is quiet.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], bus.scl_i};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], bus.sda_i};
      r_scl_d    <= w_scl;
      r_sda_d    <= w_sda;
    end
  end

  // Protocol state and datapath registers.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_state    <= S_IDLE;
      r_bit_cnt  <= 4'd0;
      r_shift    <= 8'h00;
      r_msb      <= 8'h00;
      r_byte_idx <= 1'b0;
      r_rw       <= 1'b0;
      r_ack_drv  <= 1'b0;
      r_sda_oe   <= 1'b0;
      r_data     <= 16'h0000;
      r_dv       <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_shift    <= w_shift_nxt;
      r_msb      <= w_msb_nxt;
      r_byte_idx <= w_byte_idx_nxt;
      r_rw       <= w_rw_nxt;
      r_ack_drv  <= w_ack_drv_nxt;
      r_sda_oe   <= w_sda_oe_nxt;
      r_data     <= w_data_nxt;
      r_dv       <= w_dv_nxt;
      r_busy     <= w_busy_nxt;
    end
  end

  // Next-state logic; START/STOP override whatever bit handling the state would do.
  always_comb begin
    w_state_nxt    = r_state;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_shift_nxt    = r_shift;
    w_msb_nxt      = r_msb;
    w_byte_idx_nxt = r_byte_idx;
    w_rw_nxt       = r_rw;
    w_ack_drv_nxt  = r_ack_drv;
    w_sda_oe_nxt   = r_sda_oe;
    w_data_nxt     = r_data;
    w_dv_nxt       = 1'b0;
    if (w_stop) begin
      w_state_nxt   = S_IDLE;
      w_sda_oe_nxt  = 1'b0;
      w_ack_drv_nxt = 1'b0;
    end else if (w_start) begin
      w_state_nxt    = S_ADDR;
      w_bit_cnt_nxt  = 4'd0;
      w_byte_idx_nxt = 1'b0;
      w_sda_oe_nxt   = 1'b0;
      w_ack_drv_nxt  = 1'b0;
    end else begin
      case (r_state)
        S_ADDR: begin
          if (w_scl_rise) begin
            w_shift_nxt   = w_byte_in;
            w_bit_cnt_nxt = r_bit_cnt + 4'd1;
            if (r_bit_cnt == 4'd7) begin
              w_bit_cnt_nxt = 4'd0;
              w_rw_nxt      = w_sda;
              w_state_nxt   = (r_shift[6:0] == ADDR) ? S_ADDR_ACK : S_IDLE;
            end else begin
              w_state_nxt = S_ADDR;
            end
          end else begin
            w_state_nxt = S_ADDR;
          end
        end
        S_ADDR_ACK, S_WR_ACK: begin
          if (w_scl_fall && !r_ack_drv) begin
            w_sda_oe_nxt  = 1'b1;
            w_ack_drv_nxt = 1'b1;
          end else if (w_scl_fall) begin
            w_sda_oe_nxt  = 1'b0;
            w_ack_drv_nxt = 1'b0;
            w_bit_cnt_nxt = 4'd0;
            if (!r_rw) begin
              w_state_nxt = S_WR_BYTE;
            end else begin
              // Read data must be on the bus by the same fall that ends the ACK.
              w_state_nxt   = S_RD_BYTE;
              w_sda_oe_nxt  = ~f_rd_byte(r_byte_idx, r_data)[7];
              w_shift_nxt   = {f_rd_byte(r_byte_idx, r_data)[6:0], 1'b0};
              w_bit_cnt_nxt = 4'd1;
            end
          end else begin
            w_state_nxt = r_state;
          end
        end
        S_WR_BYTE: begin
          if (w_scl_rise) begin
            w_shift_nxt   = w_byte_in;
            w_bit_cnt_nxt = r_bit_cnt + 4'd1;
            if (r_bit_cnt == 4'd7) begin
              w_bit_cnt_nxt  = 4'd0;
              w_state_nxt    = S_WR_ACK;
              w_byte_idx_nxt = ~r_byte_idx;
              if (r_byte_idx) begin
                w_data_nxt = {r_msb, w_byte_in};
                w_dv_nxt   = 1'b1;
              end else begin
                w_msb_nxt = w_byte_in;
              end
            end else begin
              w_state_nxt = S_WR_BYTE;
            end
          end else begin
            w_state_nxt = S_WR_BYTE;
          end
        end
        S_RD_BYTE: begin
          if (w_scl_fall && (r_bit_cnt == 4'd8)) begin
            w_sda_oe_nxt  = 1'b0;
            w_bit_cnt_nxt = 4'd0;
            w_state_nxt   = S_RD_ACK;
          end else if (w_scl_fall) begin
            w_sda_oe_nxt  = ~r_shift[7];
            w_shift_nxt   = {r_shift[6:0], 1'b0};
            w_bit_cnt_nxt = r_bit_cnt + 4'd1;
          end else begin
            w_state_nxt = S_RD_BYTE;
          end
        end
        S_RD_ACK: begin
          if (w_scl_rise && !w_sda) begin
            w_byte_idx_nxt = ~r_byte_idx;
            w_shift_nxt    = f_rd_byte(~r_byte_idx, r_data);
            w_bit_cnt_nxt  = 4'd0;
            w_state_nxt    = S_RD_BYTE;
          end else if (w_scl_rise) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_RD_ACK;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
    w_busy_nxt = (w_state_nxt != S_IDLE) && (w_state_nxt != S_ADDR);
  end

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: a bit-banged I2C master, a directed vector table,
// hand sequences for repeated START and mid-ACK reset, and random transfers vs a word model.
module tb_i2c_target_regs;
  localparam logic [6:0] TGT = 7'h50;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        m_scl, m_sda;
  logic [15:0] i2c_data;
  logic        data_valid, busy;

  i2c_target_regs_if bus();
  assign bus.scl_i = m_scl;
  assign bus.sda_i = m_sda & ~bus.sda_oe;

  i2c_target_regs #(.ADDR(TGT), .SYNC_STAGES(2)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .bus(bus),
    .i2c_data(i2c_data), .data_valid(data_valid), .busy(busy)
  );

  always #5 HCLK = ~HCLK;

  int          n_checks = 0, n_pass = 0;
  int          dv_cnt = 0, busy_cnt = 0, oe_cnt = 0, dv_long = 0;
  logic        dv_prev = 1'b0;
  logic [15:0] dv_q[$];
  logic [15:0] m_data;
  logic [7:0]  tx[8], rx[8];
  logic        ack_a;
  logic        ack_d[8];

  always @(posedge HCLK) begin
    if (data_valid === 1'b1) begin
      dv_cnt <= dv_cnt + 1;
      dv_q.push_back(i2c_data);
    end
    if (data_valid === 1'b1 && dv_prev) dv_long <= dv_long + 1;
    dv_prev <= (data_valid === 1'b1);
    if (busy === 1'b1) busy_cnt <= busy_cnt + 1;
    if (bus.sda_oe === 1'b1) oe_cnt <= oe_cnt + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic wc(input int n);
    repeat (n) @(negedge HCLK);
  endtask

  task automatic m_start;
    m_sda = 1'b1; wc(4); m_scl = 1'b1; wc(4); m_sda = 1'b0; wc(4); m_scl = 1'b0; wc(4);
  endtask

  task automatic m_stop;
    m_sda = 1'b0; wc(4); m_scl = 1'b1; wc(4); m_sda = 1'b1; wc(8);
  endtask

  task automatic m_bit(input logic b, output logic r);
    m_sda = b; wc(4); m_scl = 1'b1; wc(4); r = bus.sda_i; wc(4); m_scl = 1'b0; wc(4);
  endtask

  task automatic m_byte_wr(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) m_bit(b[i], r);
    m_bit(1'b1, r);
    ack = ~r;
  endtask

  task automatic m_byte_rd(input logic mack, output logic [7:0] b);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      m_bit(1'b1, r);
      b[i] = r;
    end
    m_bit(~mack, r);
  endtask

  task automatic txn(input logic rd, input logic [6:0] a, input int n);
    m_start;
    m_byte_wr({a, rd}, ack_a);
    for (int i = 0; i < n; i++) begin
      if (rd) m_byte_rd(i < n - 1, rx[i]);
      else    m_byte_wr(tx[i], ack_d[i]);
    end
    m_stop;
  endtask

  // Word model: writes commit complete byte pairs, reads return MSB,LSB,MSB,...
  task automatic run_check(input string tag, input logic rd, input logic [6:0] a, input int n);
    logic        hit;
    int          dv0, b0, o0, q0, exp_p;
    logic [15:0] exp_first, nd;
    logic [7:0]  eb;
    hit = (a == TGT);
    dv0 = dv_cnt; b0 = busy_cnt; o0 = oe_cnt; q0 = dv_q.size();
    exp_p = 0; exp_first = 16'h0000; nd = m_data;
    if (hit && !rd) begin
      for (int i = 0; i + 1 < n; i += 2) begin
        if (exp_p == 0) exp_first = {tx[i], tx[i+1]};
        nd = {tx[i], tx[i+1]};
        exp_p++;
      end
    end
    txn(rd, a, n);
    check({tag, "_addr_ack"}, ack_a, hit);
    for (int i = 0; i < n; i++) begin
      if (rd) begin
        eb = !hit ? 8'hFF : ((i % 2) == 0) ? m_data[15:8] : m_data[7:0];
        check({tag, "_rd_byte"}, rx[i], eb);
      end else begin
        check({tag, "_data_ack"}, ack_d[i], hit);
      end
    end
    m_data = nd;
    check({tag, "_data"}, i2c_data, m_data);
    check({tag, "_pulses"}, dv_cnt - dv0, exp_p);
    if (exp_p > 0) check({tag, "_first_word"}, dv_q[q0], exp_first);
    check({tag, "_busy_seen"}, busy_cnt > b0, hit);
    check({tag, "_oe_seen"}, oe_cnt > o0, hit);
    check({tag, "_idle_after_stop"}, {busy, bus.sda_oe}, 2'b00);
  endtask

  typedef struct {
    logic        rd;
    logic [6:0]  a;
    int          n;
    logic [7:0]  b0, b1, b2, b3;
    logic [15:0] exp_data;
    int          exp_pulses;
    logic [15:0] exp_first;
  } vec_t;

  vec_t tbl[6];

  initial begin
    logic [7:0] wb;
    logic       r;
    int         k, dv0, q0;

    tbl[0] = '{1'b0, 7'h50, 2, 8'h00, 8'h45, 8'h00, 8'h00, 16'h0045, 1, 16'h0045};
    tbl[1] = '{1'b0, 7'h51, 1, 8'h12, 8'h00, 8'h00, 8'h00, 16'h0045, 0, 16'h0000};
    tbl[2] = '{1'b1, 7'h50, 2, 8'h00, 8'h00, 8'h00, 8'h00, 16'h0045, 0, 16'h0000};
    tbl[3] = '{1'b0, 7'h50, 1, 8'h12, 8'h00, 8'h00, 8'h00, 16'h0045, 0, 16'h0000};
    tbl[4] = '{1'b0, 7'h50, 4, 8'h34, 8'h56, 8'h78, 8'h9A, 16'h789A, 2, 16'h3456};
    tbl[5] = '{1'b1, 7'h50, 2, 8'h00, 8'h00, 8'h00, 8'h00, 16'h789A, 0, 16'h0000};

    m_scl = 1'b1; m_sda = 1'b1; HRESETn = 1'b0;
    wc(3);
    check("reset_sda_oe", bus.sda_oe, 1'b0);
    check("reset_data", i2c_data, 16'h0000);
    check("reset_valid", data_valid, 1'b0);
    check("reset_busy", busy, 1'b0);
    HRESETn = 1'b1;
    wc(6);
    m_data = 16'h0000;

    for (int v = 0; v < 6; v++) begin
      tx[0] = tbl[v].b0; tx[1] = tbl[v].b1; tx[2] = tbl[v].b2; tx[3] = tbl[v].b3;
      dv0 = dv_cnt; q0 = dv_q.size();
      run_check($sformatf("vec%0d", v), tbl[v].rd, tbl[v].a, tbl[v].n);
      check($sformatf("vec%0d_tbl_data", v), i2c_data, tbl[v].exp_data);
      check($sformatf("vec%0d_tbl_pulses", v), dv_cnt - dv0, tbl[v].exp_pulses);
      if (tbl[v].exp_pulses > 0)
        check($sformatf("vec%0d_tbl_first", v), dv_q[q0], tbl[v].exp_first);
      if (tbl[v].rd) begin
        check($sformatf("vec%0d_tbl_rd0", v), rx[0], tbl[v].exp_data[15:8]);
        check($sformatf("vec%0d_tbl_rd1", v), rx[1], tbl[v].exp_data[7:0]);
      end
    end

    // Repeated START after a lone write byte: nothing commits, reads see current word.
    dv0 = dv_cnt;
    m_start;
    m_byte_wr({TGT, 1'b0}, ack_a);
    check("rs_wr_addr_ack", ack_a, 1'b1);
    m_byte_wr(8'h11, ack_d[0]);
    check("rs_wr_data_ack", ack_d[0], 1'b1);
    m_start;
    m_byte_wr({TGT, 1'b1}, ack_a);
    check("rs_rd_addr_ack", ack_a, 1'b1);
    m_byte_rd(1'b1, rx[0]);
    m_byte_rd(1'b0, rx[1]);
    m_stop;
    check("rs_rd_msb", rx[0], m_data[15:8]);
    check("rs_rd_lsb", rx[1], m_data[7:0]);
    check("rs_no_commit", dv_cnt - dv0, 0);
    check("rs_data", i2c_data, m_data);
    check("rs_idle", {busy, bus.sda_oe}, 2'b00);

    // Reset while the target is pulling SDA low for a data-byte ACK.
    m_start;
    m_byte_wr({TGT, 1'b0}, ack_a);
    wb = 8'hAB;
    for (int i = 7; i >= 0; i--) m_bit(wb[i], r);
    k = 0;
    while (bus.sda_oe !== 1'b1 && k < 16) begin
      wc(1);
      k++;
    end
    check("rst_ack_driven", bus.sda_oe, 1'b1);
    HRESETn = 1'b0;
    @(posedge HCLK);
    #1;
    check("rst_sda_released", bus.sda_oe, 1'b0);
    check("rst_data", i2c_data, 16'h0000);
    check("rst_busy", busy, 1'b0);
    check("rst_valid", data_valid, 1'b0);
    m_sda = 1'b1;
    wc(2);
    m_scl = 1'b1;
    wc(4);
    HRESETn = 1'b1;
    wc(8);
    m_data = 16'h0000;
    tx[0] = 8'hAB; tx[1] = 8'hCD;
    run_check("post_rst", 1'b0, TGT, 2);
    check("post_rst_word", i2c_data, 16'hABCD);

    for (int t = 0; t < 24; t++) begin
      logic       rd;
      logic [6:0] a;
      int         n;
      rd = 1'($urandom_range(0, 1));
      a  = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : TGT;
      n  = $urandom_range(1, 5);
      for (int i = 0; i < 8; i++) tx[i] = 8'($urandom);
      run_check($sformatf("rnd%0d", t), rd, a, n);
    end

    check("valid_single_cycle", dv_long, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/i2c_target_regs.md
# i2c_target_regs

Synthesizable I2C target (slave) that sits directly downstream of the SoC's I2C master (`i2c_cl_0`/`i2c_da_0`) on the open-drain bus. It oversamples SCL/SDA with the system clock, decodes START/STOP, and ACKs its 7-bit address. It accepts writes into a 16-bit data register and serves reads from it. It is the synthesizable counterpart to the behavioural slave, so that on-chip master firmware tests can run on FPGA and gate-level builds.

## Interface
- `ADDR`, 7'h50, 7-bit target address
- `SYNC_STAGES`, 2, synchronizer flops on SCL/SDA (minimum 2)
- `HCLK` input 1: system clock; sole clock
- `HRESETn` input 1: reset, synchronous, active-low
- `scl_i` input 1: SCL pin level (asynchronous)
- `sda_i` input 1: SDA pin level (asynchronous)
- `sda_oe` output 1: 1 drives SDA low; pad is open-drain, never drives high
- `i2c_data` output 16: last committed written word; read-back source
- `data_valid` output 1: one-cycle pulse when `i2c_data` updates
- `busy` output 1: high from addressed START-ack until STOP/mismatch

## Operation
- Synchronize `scl_i`/`sda_i` through `SYNC_STAGES` flops, then register once more for edge detect. `scl_rise`, `scl_fall`, `sda_rise`, `sda_fall` are single-cycle strobes.
- START: `sda_fall` while synchronized SCL high. STOP: `sda_rise` while SCL high. Both are recognised in any state and take priority over bit processing in the same cycle.
- States: IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK.
- IDLE: wait for START, then go to ADDR with bit_cnt=0 and byte_idx=0.
- ADDR: shift SDA on each `scl_rise`, MSB first, 8 bits.
  - After the 8th bit, if addr[7:1]==ADDR, go to ADDR_ACK.
  - Otherwise go to IDLE and never drive SDA; this is a NACK.
- ADDR_ACK: assert `sda_oe` on the next `scl_fall` and hold it through one SCL high period. Release it at the following `scl_fall`. Then:
  - R/W=0: go to WR_BYTE.
  - R/W=1: go to RD_BYTE, with the first bit already driven at that same fall.
- WR_BYTE: shift 8 bits into shift register, then go to WR_ACK, which ACKs like ADDR_ACK.
  - byte_idx=0: latch as staging MSB.
  - byte_idx=1: `i2c_data` <= {MSB, byte}; pulse `data_valid`. This happens the cycle after the 8th `scl_rise`, before the ACK.
  - byte_idx toggles per byte, so 3rd/4th bytes form the next word.
- RD_BYTE: shift byte = byte_idx ? `i2c_data[7:0]` : `i2c_data[15:8]`.
  - Drive bit at each `scl_fall`: `sda_oe` = ~bit.
  - After the 8th bit's `scl_fall`, release SDA and go to RD_ACK.
- RD_ACK: sample SDA at `scl_rise`.
  - Low (ACK): toggle byte_idx, go to RD_BYTE.
  - High (NACK): go to IDLE, leaving `sda_oe`=0.
- STOP in any state: go to IDLE, `sda_oe`=0, `busy`=0. A partial byte or an unpaired MSB is discarded; `i2c_data` is unchanged.
- Repeated START in any state: go to ADDR with byte_idx=0. Any staging MSB is discarded.
- `busy` is 1 in ADDR_ACK..RD_ACK and 0 otherwise.

## Timing
- Reset values, applied at the first `HCLK` edge with `HRESETn`=0:
  - state=IDLE
  - `sda_oe`=0
  - `i2c_data`=16'h0000
  - `data_valid`=0
  - `busy`=0
  - synchronizer flops=1 (bus idle high), so no spurious START/STOP out of reset.
- Reset mid-transfer: SDA is released the same cycle reset is sampled. The transfer resumes only on the next START after reset deasserts.
- Pin-to-strobe latency: SYNC_STAGES+1 `HCLK` cycles.
- `sda_oe` changes in the cycle after `scl_fall` strobe.
- Requirement: SCL low and high each ≥ SYNC_STAGES+3 `HCLK` periods. This covers 100/400 kHz at HCLK ≥ 10 MHz.
- `data_valid` is exactly one cycle and coincident with the `i2c_data` update.
- No clock stretching: SCL is never driven.

## Test plan
- Write A0, 00, 45, STOP → two address/data ACKs plus final ACK; `i2c_data`=16'h0045 (69); exactly one `data_valid` pulse; `busy` falls after STOP.
- Write A2 (wrong address), 12 → SDA never driven low, no ACK, `i2c_data` unchanged, `busy`=0 throughout.
- After `i2c_data`=16'h0045: A1, then master ACKs byte 1 and NACKs byte 2 → bus reads 00 then 45; `sda_oe`=0 after NACK; state IDLE at STOP.
- Write A0, 12, STOP (single byte), then A0, 34, 56, 78, 9A, STOP → `i2c_data`=16'h3456, then 16'h789A, with two `data_valid` pulses; 0x12 discarded.
- Write A0, 11, repeated START, A1, read 2 bytes → no commit of 0x11; reads return the current `i2c_data` MSB then LSB.
- Drive `HRESETn` low during WR_ACK while `sda_oe`=1 → `sda_oe`=0 the next cycle and all outputs at reset values. A subsequent full write A0, AB, CD → 16'hABCD.
